// File: rtl/wb_bridge_nway.sv
// N-way Wishbone classic bridge: one upstream slave port routed to N_PORTS downstream
// masters by base/mask windows, with a bus watchdog and a miss/timeout status register.

module wb_bridge_win #(
  parameter logic [31:0] BASE = 32'h0,
  parameter logic [31:0] MASK = 32'h0
) (
  input  logic [31:0] adr,
  output logic        hit
);
  assign hit = (adr & MASK) == (BASE & MASK);
endmodule

module wb_bridge_nway #(
  parameter int                    N_PORTS     = 4,
  parameter logic [32*N_PORTS-1:0] PORT_BASE   = {N_PORTS{32'h3000_0000}},
  parameter logic [32*N_PORTS-1:0] PORT_MASK   = {N_PORTS{32'hFFFF_F000}},
  parameter logic [31:0]           STATUS_ADDR = 32'h30FF_FFFC,
  parameter int                    TIMEOUT     = 255,
  parameter logic [31:0]           ERR_DATA    = 32'hDEAD_BEEF
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_n_i,
  input  logic                   wbs_stb_i,
  input  logic                   wbs_cyc_i,
  input  logic                   wbs_we_i,
  input  logic [3:0]             wbs_sel_i,
  input  logic [31:0]            wbs_adr_i,
  input  logic [31:0]            wbs_dat_i,
  output logic                   wbs_ack_o,
  output logic [31:0]            wbs_dat_o,
  output logic [N_PORTS-1:0]     wbm_stb_o,
  output logic [N_PORTS-1:0]     wbm_cyc_o,
  output logic                   wbm_we_o,
  output logic [3:0]             wbm_sel_o,
  output logic [31:0]            wbm_adr_o,
  output logic [31:0]            wbm_dat_o,
  input  logic [N_PORTS-1:0]     wbm_ack_i,
  input  logic [32*N_PORTS-1:0]  wbm_dat_i,
  output logic                   irq_o
);
  localparam int              WD_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, FWD, RESP} state_t;

  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
  } wb_req_t;

  state_t             state_q, state_d;
  wb_req_t            req_q, req_d;
  logic [N_PORTS-1:0] port_q, port_d;
  logic [N_PORTS-1:0] hit, pick;
  logic [31:0]        rdata_q, rdata_d;
  logic [31:0]        dat_o_q, dat_o_d;
  logic [31:0]        fwd_dat, status;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic [7:0]         miss_q, miss_d, to_q, to_d;
  logic               irq_q, irq_d, ack_q, ack_d;
  logic               req_acc, stat_hit, any_hit, ack_sel, to_fire;
  logic               clr, miss_inc, to_inc;

  for (genvar g = 0; g < N_PORTS; g++) begin : g_win
    wb_bridge_win #(
      .BASE (PORT_BASE[32*g +: 32]),
      .MASK (PORT_MASK[32*g +: 32])
    ) u_win (
      .adr (wbs_adr_i),
      .hit (hit[g])
    );
  end

  // Lowest set bit of the hit vector wins when windows overlap.
  assign pick     = hit & (~hit + N_PORTS'(1));
  assign any_hit  = |hit;
  assign stat_hit = (wbs_adr_i == STATUS_ADDR);
  // The ack of the previous access is still on the bus while ack_q is high.
  assign req_acc  = (state_q == IDLE) && wbs_cyc_i && wbs_stb_i && !ack_q;
  assign ack_sel  = |(wbm_ack_i & port_q);
  assign to_fire  = (TIMEOUT != 0) && (wd_q == WD_LAST);
  assign status   = {8'h00, to_q, miss_q, 8'(N_PORTS)};

  always_comb begin
    fwd_dat = '0;
    for (int i = 0; i < N_PORTS; i++)
      if (port_q[i]) fwd_dat = fwd_dat | wbm_dat_i[32*i +: 32];
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) state_q <= IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (req_acc) state_d = (stat_hit || !any_hit) ? RESP : FWD;
      FWD: begin
        if (!wbs_cyc_i)               state_d = IDLE;
        else if (ack_sel || to_fire)  state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wbm_stb_o = '0;
    wbm_cyc_o = '0;
    if (state_q == FWD) begin
      wbm_stb_o = port_q;
      wbm_cyc_o = port_q;
    end
  end

  assign wbm_we_o  = req_q.we;
  assign wbm_sel_o = req_q.sel;
  assign wbm_adr_o = req_q.adr;
  assign wbm_dat_o = req_q.dat;
  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_o_q;
  assign irq_o     = irq_q;

  always_comb begin
    req_d    = req_q;
    port_d   = port_q;
    rdata_d  = rdata_q;
    wd_d     = '0;
    clr      = 1'b0;
    miss_inc = 1'b0;
    to_inc   = 1'b0;
    if (req_acc) begin
      req_d = {wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i};
      if (stat_hit) begin
        rdata_d = status;
        clr     = wbs_we_i;
      end else if (any_hit) begin
        port_d = pick;
      end else begin
        rdata_d  = ERR_DATA;
        miss_inc = 1'b1;
      end
    end
    if (state_q == FWD && wbs_cyc_i) begin
      wd_d = wd_q + WD_W'(1);
      // A real ack beats a watchdog expiry in the same cycle.
      if (ack_sel) begin
        rdata_d = fwd_dat;
      end else if (to_fire) begin
        rdata_d = ERR_DATA;
        to_inc  = 1'b1;
      end
    end
    miss_d  = clr ? 8'h00 : (miss_inc && miss_q != 8'hFF) ? miss_q + 8'd1 : miss_q;
    to_d    = clr ? 8'h00 : (to_inc && to_q != 8'hFF) ? to_q + 8'd1 : to_q;
    irq_d   = clr ? 1'b0 : (irq_q | miss_inc | to_inc);
    ack_d   = (state_q == RESP);
    dat_o_d = (state_q == RESP) ? rdata_q : 32'h0;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      req_q   <= '0;
      port_q  <= '0;
      rdata_q <= '0;
      dat_o_q <= '0;
      wd_q    <= '0;
      miss_q  <= '0;
      to_q    <= '0;
      irq_q   <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      req_q   <= req_d;
      port_q  <= port_d;
      rdata_q <= rdata_d;
      dat_o_q <= dat_o_d;
      wd_q    <= wd_d;
      miss_q  <= miss_d;
      to_q    <= to_d;
      irq_q   <= irq_d;
      ack_q   <= ack_d;
    end
  end
endmodule

// File: tb/tb_wb_bridge_nway.sv
// Randomized scoreboard bench for wb_bridge_nway: a driver issues upstream accesses and
// queues expected responses from a window/counter model; a monitor checks every bus event.

module tb_wb_bridge_nway;
  localparam int          NP   = 4;
  localparam int          TO   = 8;
  localparam logic [31:0] STAT = 32'h30FF_FFFC;
  localparam logic [31:0] ERR  = 32'hDEAD_BEEF;
  localparam logic [32*NP-1:0] P_BASE =
    {32'h3001_0000, 32'h3000_3000, 32'h3000_2000, 32'h3000_0000};
  localparam logic [32*NP-1:0] P_MASK =
    {32'hFFFF_0000, 32'hFFFF_F000, 32'hFFFF_E000, 32'hFFFF_F000};

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0]        wbs_sel_i = '0;
  logic [31:0]       wbs_adr_i = '0, wbs_dat_i = '0;
  logic              wbs_ack_o;
  logic [31:0]       wbs_dat_o;
  logic [NP-1:0]     wbm_stb_o, wbm_cyc_o;
  logic              wbm_we_o;
  logic [3:0]        wbm_sel_o;
  logic [31:0]       wbm_adr_o, wbm_dat_o;
  logic [NP-1:0]     wbm_ack_i = '0;
  logic [32*NP-1:0]  wbm_dat_i = '0;
  logic              irq_o;

  wb_bridge_nway #(
    .N_PORTS(NP), .PORT_BASE(P_BASE), .PORT_MASK(P_MASK),
    .STATUS_ADDR(STAT), .TIMEOUT(TO), .ERR_DATA(ERR)
  ) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .wbm_stb_o(wbm_stb_o), .wbm_cyc_o(wbm_cyc_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] dat; bit chk_dat; bit irq; int cyc; } up_t;
  typedef struct { logic [NP-1:0] oh; logic we; logic [3:0] sel;
                   logic [31:0] adr; logic [31:0] dat; int cyc; } ds_t;

  up_t         up_q[$];
  ds_t         ds_q[$];
  up_t         mon_u;
  ds_t         mon_d;
  bit          ds_prev = 0;
  int          checks = 0, failures = 0, cyc_cnt = 0;
  int          slv_lat = 0, slv_cnt = 0;
  logic [31:0] slv_dat = '0;

  // Reference model: windows as plain tables, counters as saturating integers.
  logic [31:0] m_base [NP] = '{32'h3000_0000, 32'h3000_2000, 32'h3000_3000, 32'h3001_0000};
  logic [31:0] m_mask [NP] = '{32'hFFFF_F000, 32'hFFFF_E000, 32'hFFFF_F000, 32'hFFFF_0000};
  int          m_miss = 0, m_to = 0;
  bit          m_irq = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h cycle=%0d", nm, act, exp, cyc_cnt);
    end
  endtask

  function automatic int find_port(input logic [31:0] a);
    for (int i = 0; i < NP; i++)
      if ((a & m_mask[i]) == (m_base[i] & m_mask[i])) return i;
    return -1;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stb"}, 32'(wbm_stb_o), 0);
    chk({tag, "_cyc"}, 32'(wbm_cyc_o), 0);
    chk({tag, "_ack"}, 32'(wbs_ack_o), 0);
    chk({tag, "_sdat"}, wbs_dat_o, 0);
    chk({tag, "_we"}, 32'(wbm_we_o), 0);
    chk({tag, "_sel"}, 32'(wbm_sel_o), 0);
    chk({tag, "_adr"}, wbm_adr_o, 0);
    chk({tag, "_mdat"}, wbm_dat_o, 0);
    chk({tag, "_irq"}, 32'(irq_o), 0);
  endtask

  // Downstream slaves: the strobed port acks after slv_lat stb cycles (0 = never);
  // unselected ports throw random acks and data that must be ignored.
  initial begin
    forever begin
      @(posedge clk); #1;
      slv_cnt   = (|wbm_stb_o) ? slv_cnt + 1 : 0;
      wbm_ack_i = NP'($urandom) & ~wbm_stb_o;
      if ((|wbm_stb_o) && slv_lat != 0 && slv_cnt == slv_lat)
        wbm_ack_i = wbm_ack_i | wbm_stb_o;
      for (int i = 0; i < NP; i++)
        wbm_dat_i[32*i +: 32] = wbm_stb_o[i] ? slv_dat : $urandom;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ds_prev = 0;
      end else begin
        if (wbs_ack_o) begin
          if (up_q.size() == 0) chk("unexpected_ack", 1, 0);
          else begin
            mon_u = up_q.pop_front();
            if (mon_u.chk_dat) chk("rdata", wbs_dat_o, mon_u.dat);
            chk("ack_cycle", cyc_cnt, mon_u.cyc);
            chk("irq", 32'(irq_o), 32'(mon_u.irq));
          end
        end else begin
          chk("dat_zero_no_ack", wbs_dat_o, 0);
        end
        if ((|wbm_stb_o) && !ds_prev) begin
          if (ds_q.size() == 0) chk("unexpected_stb", 32'(wbm_stb_o), 0);
          else begin
            mon_d = ds_q.pop_front();
            chk("ds_stb", 32'(wbm_stb_o), 32'(mon_d.oh));
            chk("ds_cyc", 32'(wbm_cyc_o), 32'(mon_d.oh));
            chk("ds_we", 32'(wbm_we_o), 32'(mon_d.we));
            chk("ds_sel", 32'(wbm_sel_o), 32'(mon_d.sel));
            chk("ds_adr", wbm_adr_o, mon_d.adr);
            if (mon_d.we) chk("ds_wdat", wbm_dat_o, mon_d.dat);
            chk("ds_cycle", cyc_cnt, mon_d.cyc);
          end
        end
        ds_prev = |wbm_stb_o;
      end
    end
  end

  task automatic access(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                        input logic [31:0] dat, input int lat, input logic [31:0] rdat);
    int  t0, p;
    bit  got;
    up_t e;
    ds_t d;
    @(posedge clk); #1;
    t0 = cyc_cnt;
    slv_lat = lat;
    slv_dat = rdat;
    e.chk_dat = 1;
    if (adr == STAT) begin
      e.dat     = {8'h00, 8'(m_to), 8'(m_miss), 8'(NP)};
      e.chk_dat = !we;
      e.cyc     = t0 + 2;
      if (we) begin m_miss = 0; m_to = 0; m_irq = 0; end
    end else begin
      p = find_port(adr);
      if (p < 0) begin
        e.dat  = ERR;
        e.cyc  = t0 + 2;
        m_miss = (m_miss < 255) ? m_miss + 1 : 255;
        m_irq  = 1;
      end else begin
        d.oh = NP'(1) << p; d.we = we; d.sel = sel; d.adr = adr; d.dat = dat; d.cyc = t0 + 1;
        ds_q.push_back(d);
        if (lat >= 1 && lat <= TO) begin
          e.dat = rdat;
          e.cyc = t0 + lat + 2;
        end else begin
          e.dat = ERR;
          e.cyc = t0 + TO + 2;
          m_to  = (m_to < 255) ? m_to + 1 : 255;
          m_irq = 1;
        end
      end
    end
    e.irq = m_irq;
    up_q.push_back(e);
    wbs_adr_i = adr; wbs_we_i = we; wbs_sel_i = sel; wbs_dat_i = dat;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    got = 0;
    for (int n = 0; n < TO + 20; n++) begin
      @(negedge clk);
      if (wbs_ack_o) begin got = 1; break; end
    end
    if (!got) begin
      chk("ack_wait_expired", 0, 1);
      up_q.delete();
      ds_q.delete();
    end
    @(posedge clk); #1;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit actual=running expected=finished");
    $fatal(1, "time limit");
  end

  initial begin
    int          t0;
    ds_t         d;
    logic [31:0] a;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;

    access(32'h3000_0004, 1'b0, 4'hF, 32'h0, 2, 32'h1234_5678);
    access(32'h3000_3010, 1'b1, 4'b0011, 32'hA5A5_A5A5, 1, 32'h0BAD_F00D);
    access(32'h2000_0000, 1'b0, 4'hF, 32'h0, 1, 32'h0);
    access(STAT, 1'b0, 4'hF, 32'h0, 1, 32'h0);
    access(32'h3000_0100, 1'b0, 4'hF, 32'h0, 0, 32'h0);
    access(STAT, 1'b0, 4'hF, 32'h0, 1, 32'h0);
    access(STAT, 1'b1, 4'hF, 32'h0, 1, 32'h0);
    access(STAT, 1'b0, 4'hF, 32'h0, 1, 32'h0);
    access(32'h3000_2040, 1'b0, 4'hF, 32'h0, TO, 32'hCAFE_0008);
    access(32'h3000_2044, 1'b0, 4'hF, 32'h0, TO + 1, 32'hCAFE_0009);
    access(32'h3001_0080, 1'b0, 4'hF, 32'h0, 1, 32'h5555_AAAA);

    // Upstream abandons the cycle while the slave is silent.
    @(posedge clk); #1;
    t0 = cyc_cnt;
    slv_lat = 0;
    d.oh = 4'b0001; d.we = 1'b0; d.sel = 4'hF; d.adr = 32'h3000_0200; d.dat = 32'h0; d.cyc = t0 + 1;
    ds_q.push_back(d);
    wbs_adr_i = 32'h3000_0200; wbs_we_i = 1'b0; wbs_sel_i = 4'hF;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    @(negedge clk); chk("abort_cyc_hold", 32'(wbm_cyc_o), 32'h1);
    @(negedge clk); chk("abort_cyc_drop", 32'(wbm_cyc_o), 32'h0);
    repeat (4) @(negedge clk);
    access(32'h3000_0204, 1'b0, 4'hF, 32'h0, 3, 32'h0A0B_0C0D);

    // Reset pulse in the middle of a forwarded access to port 3.
    @(posedge clk); #1;
    t0 = cyc_cnt;
    slv_lat = 0;
    d.oh = 4'b1000; d.we = 1'b0; d.sel = 4'hF; d.adr = 32'h3001_0040; d.dat = 32'h0; d.cyc = t0 + 1;
    ds_q.push_back(d);
    wbs_adr_i = 32'h3001_0040; wbs_we_i = 1'b0;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midfwd_reset");
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    m_miss = 0; m_to = 0; m_irq = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    access(32'h3001_0040, 1'b0, 4'hF, 32'h0, 2, 32'h3333_4444);
    access(STAT, 1'b0, 4'hF, 32'h0, 1, 32'h0);

    // Drive the miss counter into saturation.
    for (int i = 0; i < 258; i++) access(32'h2000_0000 + 32'(i * 4), 1'b0, 4'hF, 32'h0, 1, 32'h0);
    access(STAT, 1'b0, 4'hF, 32'h0, 1, 32'h0);
    access(STAT, 1'b1, 4'hF, 32'h0, 1, 32'h0);

    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 6))
        0:       a = 32'h3000_0000 | ($urandom & 32'h0000_0FFC);
        1:       a = 32'h3000_2000 | ($urandom & 32'h0000_0FFC);
        2:       a = 32'h3000_3000 | ($urandom & 32'h0000_0FFC);
        3:       a = 32'h3001_0000 | ($urandom & 32'h0000_FFFC);
        4:       a = $urandom;
        5:       a = STAT;
        default: a = 32'h3000_1000 | ($urandom & 32'h0000_0FFC);
      endcase
      access(a, 1'($urandom_range(0, 1)), 4'($urandom), $urandom,
             $urandom_range(0, TO + 2), $urandom);
    end
    access(STAT, 1'b0, 4'hF, 32'h0, 1, 32'h0);
    repeat (4) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
